// File: rtl/mult_error_monitor_if.sv
// Operand/product stream and statistics bus between an NxN multiplier
// environment and its error-metric monitor.
interface mult_error_monitor_if #(
   parameter int N     = 8,
   parameter int ACC_W = 40,
   parameter int CNT_W = 17
);
   logic             start;
   logic             in_valid;
   logic             in_last;
   logic [N-1:0]     in_a;
   logic [N-1:0]     in_b;
   logic [2*N-1:0]   p_approx;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] test_count;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] nonzero_count;
   logic [ACC_W-1:0] sum_ed;
   logic [2*N-1:0]   max_ed;

   modport master (
      output start, in_valid, in_last, in_a, in_b, p_approx,
      input  busy, done, test_count, err_count, nonzero_count, sum_ed, max_ed
   );

   modport slave (
      input  start, in_valid, in_last, in_a, in_b, p_approx,
      output busy, done, test_count, err_count, nonzero_count, sum_ed, max_ed
   );
endinterface

// File: rtl/mult_error_monitor.sv
// Error-metric accumulator behind an (approximate) multiplier: aligns operands
// with the registered product, computes |P - A*B| and gathers run statistics.
module mult_error_monitor #(
   parameter int N     = 8,
   parameter int LAT   = 1,
   parameter int ACC_W = 40,
   parameter int CNT_W = 17
) (
   input logic                 clk,
   input logic                 rst,
   mult_error_monitor_if.slave bus
);
   localparam int PW = 2 * N;
   localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [LAT-1:0]   dl_vld;
   logic [N-1:0]     dl_a [LAT];
   logic [N-1:0]     dl_b [LAT];

   logic             accept;
   logic             clear;
   logic             chk_vld;
   logic [PW-1:0]    exact;
   logic [PW:0]      diff;
   logic [PW:0]      diff_abs;
   logic [PW-1:0]    ed;
   logic [SW-1:0]    sum_wide;
   logic [ACC_W-1:0] sum_nxt;

   logic [CNT_W-1:0] test_cnt, err_cnt, nz_cnt;
   logic [ACC_W-1:0] sum_r;
   logic [PW-1:0]    max_r;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign accept = (state == RUN) && bus.in_valid;
   assign clear  = (state == IDLE) && bus.start;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      unique case (state)
         IDLE:  if (bus.start) state_nxt = RUN;
         RUN: begin
            bus.busy = 1'b1;
            if (bus.in_valid && bus.in_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            bus.busy = 1'b1;
            // Delay line empty means the last pair was checked on the previous edge
            if (dl_vld == '0) state_nxt = DONE;
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dl_vld <= '0;
      end else begin
         dl_vld[0] <= accept;
         for (int unsigned i = 1; i < LAT; i++) dl_vld[i] <= dl_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      dl_a[0] <= bus.in_a;
      dl_b[0] <= bus.in_b;
      for (int unsigned i = 1; i < LAT; i++) begin
         dl_a[i] <= dl_a[i-1];
         dl_b[i] <= dl_b[i-1];
      end
   end

   always_comb begin
      chk_vld  = dl_vld[LAT-1];
      exact    = PW'(dl_a[LAT-1]) * PW'(dl_b[LAT-1]);
      diff     = {1'b0, bus.p_approx} - {1'b0, exact};
      diff_abs = diff[PW] ? (~diff + (PW+1)'(1)) : diff;
      ed       = diff_abs[PW-1:0];
      // Widened add so a single ED larger than the accumulator still saturates
      sum_wide = SW'(sum_r) + SW'(ed);
      sum_nxt  = (sum_wide > SW'({ACC_W{1'b1}})) ? '1 : sum_wide[ACC_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         test_cnt <= '0;
         err_cnt  <= '0;
         nz_cnt   <= '0;
         sum_r    <= '0;
         max_r    <= '0;
      end else if (chk_vld) begin
         test_cnt <= sat_inc(test_cnt);
         if (ed != '0)    err_cnt <= sat_inc(err_cnt);
         if (exact != '0) nz_cnt  <= sat_inc(nz_cnt);
         sum_r <= sum_nxt;
         if (ed > max_r) max_r <= ed;
      end
   end

   assign bus.test_count    = test_cnt;
   assign bus.err_count     = err_cnt;
   assign bus.nonzero_count = nz_cnt;
   assign bus.sum_ed        = sum_r;
   assign bus.max_ed        = max_r;
endmodule

// File: tb/tb_mult_error_monitor.sv
// Randomized bench for mult_error_monitor: a latency-LAT product pipe stands in
// for the multiplier, and run statistics are recomputed from the pair list.
module tb_mult_error_monitor;
   localparam int N     = 8;
   localparam int LAT   = 3;
   localparam int ACC_W = 20;
   localparam int CNT_W = 17;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          gap;
   } pair_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] prod_in;
   logic [15:0] ppipe [LAT];
   pair_t       q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   mult_error_monitor_if #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   mult_error_monitor #(.N(N), .LAT(LAT), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Approximate-multiplier stand-in: product presented LAT cycles after operands
   always @(posedge clk) begin
      ppipe[0] <= prod_in;
      for (int i = 1; i < LAT; i++) ppipe[i] <= ppipe[i-1];
   end
   assign bus.p_approx = ppipe[LAT-1];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int a, input int b, input int p, input int gap);
      pair_t e;
      e.a = 8'(a); e.b = 8'(b); e.p = 16'(p); e.gap = gap;
      q.push_back(e);
   endtask

   task automatic drive_junk(input logic valid, input logic last, input logic st);
      bus.start    = st;
      bus.in_valid = valid;
      bus.in_last  = last;
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      prod_in      = 16'($urandom);
   endtask

   // Statistics straight from the definition: clamp once at the end (all monotonic)
   task automatic model_stats(output longint t, output longint e, output longint nz,
                              output longint s, output longint m);
      longint cmax = (longint'(1) << CNT_W) - 1;
      longint smax = (longint'(1) << ACC_W) - 1;
      t = 0; e = 0; nz = 0; s = 0; m = 0;
      foreach (q[i]) begin
         longint ex = longint'(q[i].a) * longint'(q[i].b);
         longint d  = longint'(q[i].p) - ex;
         if (d < 0) d = -d;
         t++;
         if (d != 0)  e++;
         if (ex != 0) nz++;
         s += d;
         if (d > m) m = d;
      end
      if (t > cmax)  t = cmax;
      if (e > cmax)  e = cmax;
      if (nz > cmax) nz = cmax;
      if (s > smax)  s = smax;
   endtask

   task automatic do_run(input string name, input bit start_in_gaps);
      longint t, e, nz, s, m;
      // start with a simultaneous in_valid/in_last: that operand must be ignored
      drive_junk(1'b1, 1'b1, 1'b1);
      step();
      foreach (q[i]) begin
         repeat (q[i].gap) begin
            drive_junk(1'b0, 1'b0, start_in_gaps);
            step();
         end
         bus.start    = 1'b0;
         bus.in_valid = 1'b1;
         bus.in_last  = (i == q.size() - 1);
         bus.in_a     = q[i].a;
         bus.in_b     = q[i].b;
         prod_in      = q[i].p;
         step();
      end
      drive_junk(1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= LAT + 2; k++) begin
         step();
         check_eq({name, " done"}, 64'(bus.done), 64'(k == LAT + 1));
         check_eq({name, " busy"}, 64'(bus.busy), 64'(k <= LAT));
      end
      // in_valid while IDLE is ignored and results hold
      repeat (3) begin
         drive_junk(1'b1, 1'($urandom), 1'b0);
         step();
      end
      drive_junk(1'b0, 1'b0, 1'b0);
      model_stats(t, e, nz, s, m);
      check_eq({name, " test_count"},    64'(bus.test_count),    64'(t));
      check_eq({name, " err_count"},     64'(bus.err_count),     64'(e));
      check_eq({name, " nonzero_count"}, 64'(bus.nonzero_count), 64'(nz));
      check_eq({name, " sum_ed"},        64'(bus.sum_ed),        64'(s));
      check_eq({name, " max_ed"},        64'(bus.max_ed),        64'(m));
   endtask

   task automatic build_random(input int n, input bit wild);
      q.delete();
      for (int i = 0; i < n; i++) begin
         int a = int'($urandom_range(0, 255));
         int b = int'($urandom_range(0, 255));
         int p = a * b;
         int gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
         if (wild) begin
            p = int'($urandom_range(0, 65535));
         end else begin
            case ($urandom_range(0, 3))
               1: p = p + int'($urandom_range(0, 600)) - 300;
               2: p = int'($urandom_range(0, 65535));
               default: ;
            endcase
            if (p < 0) p = 0;
            if (p > 65535) p = 65535;
         end
         add(a, b, p, gap);
      end
   endtask

   initial begin
      bit seen_done;
      rst = 1'b1;
      drive_junk(1'b0, 1'b0, 1'b0);
      step();
      step();
      rst = 1'b0;
      check_eq("reset busy",       64'(bus.busy),          64'(0));
      check_eq("reset done",       64'(bus.done),          64'(0));
      check_eq("reset test_count", 64'(bus.test_count),    64'(0));
      check_eq("reset err_count",  64'(bus.err_count),     64'(0));
      check_eq("reset nz_count",   64'(bus.nonzero_count), 64'(0));
      check_eq("reset sum_ed",     64'(bus.sum_ed),        64'(0));
      check_eq("reset max_ed",     64'(bus.max_ed),        64'(0));

      // in_valid in IDLE without start is not counted
      repeat (4) begin
         drive_junk(1'b1, 1'b0, 1'b0);
         step();
         check_eq("idle busy", 64'(bus.busy), 64'(0));
      end
      check_eq("idle test_count", 64'(bus.test_count), 64'(0));

      // Exhaustive exact sweep, back-to-back
      q.delete();
      for (int a = 0; a < 256; a++)
         for (int b = 0; b < 256; b++) add(a, b, a * b, 0);
      do_run("sweep", 1'b0);

      q.delete();
      add(10, 20, 203, 0); add(0, 5, 0, 0); add(7, 7, 49, 0);
      do_run("single_err", 1'b0);

      q.delete();
      add(255, 255, 0, 0); add(3, 4, 100, 0);
      do_run("under_over", 1'b0);

      // Gapped valid pattern 1,0,0,1,1
      q.delete();
      add(12, 13, 156, 0); add(200, 2, 401, 2); add(9, 9, 80, 0);
      do_run("gapped", 1'b0);

      // rst two cycles into a run: no done, everything cleared
      drive_junk(1'b0, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 2; i++) begin
         bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_last = 1'b0;
         bus.in_a = 8'(50 + i); bus.in_b = 8'(3); prod_in = 16'($urandom);
         step();
      end
      rst = 1'b1;
      drive_junk(1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      check_eq("rst_mid busy",       64'(bus.busy),       64'(0));
      check_eq("rst_mid test_count", 64'(bus.test_count), 64'(0));
      check_eq("rst_mid sum_ed",     64'(bus.sum_ed),     64'(0));
      seen_done = 1'b0;
      repeat (LAT + 4) begin
         step();
         seen_done |= bus.done;
      end
      check_eq("rst_mid no_done",    64'(seen_done),      64'(0));
      check_eq("rst_mid test_count2", 64'(bus.test_count), 64'(0));

      // Random runs; start pulses during gaps must be ignored
      for (int r = 0; r < 6; r++) begin
         build_random(int'($urandom_range(5, 60)), 1'b0);
         do_run($sformatf("rand%0d", r), bit'(r % 2));
      end
      // Large random errors drive sum_ed into saturation
      build_random(120, 1'b1);
      do_run("saturate", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
